// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the round-robin double-dabble BCD converter.
// Optional leading-zero blanking is enabled in the top with macro BCD_BLANK_EN.
package bcd_conv_pkg;

   typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_e;

   localparam logic [3:0] BCD_BLANK  = 4'hF;
   localparam logic [3:0] ADJ_THRESH = 4'd4;
   localparam logic [3:0] ADJ_ADD    = 4'd3;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Serial double-dabble datapath: {BCD field, binary field} shift register with
// per-nibble add-3 adjust. Sequencing is supplied by the caller via strobes.
module bcd_dabble_core
   import bcd_conv_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int BCD_DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    load_i,
   input  logic                    adj_i,
   input  logic                    shift_i,
   input  logic [DATA_W-1:0]       data_i,
   output logic [4*BCD_DIGITS-1:0] bcd_nxt_o
);

   localparam int SR_W = 4*BCD_DIGITS + DATA_W;

   logic [SR_W-1:0] sr_q, sr_d, sr_adj;

   always_comb begin
      sr_adj = sr_q;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (sr_q[DATA_W + d*4 +: 4] > ADJ_THRESH)
            sr_adj[DATA_W + d*4 +: 4] = sr_q[DATA_W + d*4 +: 4] + ADJ_ADD;
      end
   end

   always_comb begin
      sr_d = sr_q;
      if (load_i)       sr_d = {{(4*BCD_DIGITS){1'b0}}, data_i};
      else if (adj_i)   sr_d = sr_adj;
      else if (shift_i) sr_d = {sr_q[SR_W-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      sr_q <= sr_d;
   end

   // BCD field as it will look after the pending shift; lets the caller
   // capture the final result on the last SHIFT edge.
   assign bcd_nxt_o = sr_q[SR_W-2 -: 4*BCD_DIGITS];

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one serial binary-to-BCD engine among NUM_REQ requesters.
// Macro BCD_BLANK_EN: blank leading zero digits (digit 0 never) with 4'hF.
module bcd_conv_sched
   import bcd_conv_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 8,
   parameter int BCD_DIGITS = 3
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [4*BCD_DIGITS-1:0]     rsp_bcd,
   output logic                        busy
);

   localparam int ID_W  = clog2(NUM_REQ);
   localparam int CNT_W = (DATA_W > 1) ? clog2(DATA_W) : 1;
   localparam int BCD_W = 4*BCD_DIGITS;

   if (pow10(BCD_DIGITS) <= (longint'(1) << DATA_W) - 1) begin : g_bad_digits
      $error("BCD_DIGITS too small for DATA_W");
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [BCD_W-1:0]  rsp_bcd_q, rsp_bcd_d;

   logic              win_found;
   logic [ID_W-1:0]   win;
   logic              load, adj, shift;
   logic [BCD_W-1:0]  bcd_nxt, bcd_out;

   // Search starts just past the last served requester.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win       = '0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_q) + k) % NUM_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win       = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && win_found) req_ready[win] = 1'b1;
   end

   bcd_dabble_core #(
      .DATA_W     (DATA_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_core (
      .clk       (sys_clk),
      .load_i    (load),
      .adj_i     (adj),
      .shift_i   (shift),
      .data_i    (req_data[win*DATA_W +: DATA_W]),
      .bcd_nxt_o (bcd_nxt)
   );

`ifdef BCD_BLANK_EN
   always_comb begin
      logic lead;
      bcd_out = bcd_nxt;
      lead    = 1'b1;
      for (int d = BCD_DIGITS-1; d >= 1; d--) begin
         if (lead && bcd_nxt[d*4 +: 4] == 4'd0) bcd_out[d*4 +: 4] = BCD_BLANK;
         else                                   lead = 1'b0;
      end
   end
`else
   assign bcd_out = bcd_nxt;
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      last_d      = last_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_bcd_d   = rsp_bcd_q;
      load        = 1'b0;
      adj         = 1'b0;
      shift       = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               load      = 1'b1;
               bit_cnt_d = '0;
               id_d      = win;
               state_d   = ADJ;
            end
         end
         ADJ: begin
            adj     = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            shift     = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_bcd_d   = bcd_out;
               state_d     = DONE;
            end else begin
               state_d = ADJ;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               last_d      = id_q;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         last_q      <= ID_W'(NUM_REQ-1);
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_bcd_q   <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         last_q      <= last_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_bcd_q   <= rsp_bcd_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_bcd   = rsp_bcd_q;
   assign busy      = (state_q != IDLE);

endmodule
